pipelined_barrel_shifter: RTL and testbench

- Parametrised, pipelined barrel shifter; successor to the fixed 32-bit combinational right-shift stage chain.
- Supports logical left, logical right, arithmetic right, rotate right and rotate left.
- One log2 stage per shift-amount bit, with registers inserted every REG_EVERY stages.
- Valid/ready handshake with full backpressure; sits between the ALU operand decode and the ALU result mux.

---
 rtl/alu_shift_pkg.sv | 25 ++
 rtl/shift_stage.sv | 27 ++
 rtl/pipelined_barrel_shifter.sv | 133 +++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_shift_pkg.sv
// Shared shift-unit types and mode helpers.
// Used by the barrel shifter pipeline and its stages.
package alu_shift_pkg;

    typedef enum logic [2:0] {
        SH_SLL = 3'd0,
        SH_SRL = 3'd1,
        SH_SRA = 3'd2,
        SH_ROR = 3'd3,
        SH_ROL = 3'd4
    } shift_mode_t;

    function automatic logic is_left(shift_mode_t mode);
        return (mode == SH_SLL) || (mode == SH_ROL);
    endfunction

    function automatic logic is_rotate(shift_mode_t mode);
        return (mode == SH_ROR) || (mode == SH_ROL);
    endfunction

    function automatic logic is_legal(logic [2:0] mode);
        return mode <= 3'd4;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One log2 right-type shift stage of fixed distance.
// Shifts in the fill bit or wraps the low bits for rotates.
module shift_stage #(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             fill,
    input  logic             rotate,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] shifted;

    // Right shift by DIST, top bits from fill or wrapped low bits
    always_comb begin
        if (rotate) begin
            shifted = {data[DIST-1:0], data[WIDTH-1:DIST]};
        end else begin
            shifted = {{DIST{fill}}, data[WIDTH-1:DIST]};
        end
    end

    assign result = en ? shifted : data;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: log2 stages with register slots
// every REG_EVERY stages and full valid/ready backpressure.
module pipelined_barrel_shifter
    import alu_shift_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int REG_EVERY = 1,
    localparam int SHAMT_W   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [2:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);

    localparam int LATENCY = (SHAMT_W + REG_EVERY - 1) / REG_EVERY;

    typedef struct packed {
        logic               valid;
        logic [WIDTH-1:0]   data;
        logic [SHAMT_W-1:0] shamt;
        shift_mode_t        mode;
        logic               fill;
    } slot_t;

    slot_t            slot_q [LATENCY];
    slot_t            entry;
    shift_mode_t      entry_mode;
    logic [LATENCY-1:0] rdy;
    logic             rot    [LATENCY];
    logic [WIDTH-1:0] grp    [LATENCY];
    logic [WIDTH-1:0] st_out [SHAMT_W];

    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = x[WIDTH-1-i];
        end
        return r;
    endfunction

    assign entry_mode = shift_mode_t'(in_mode);

    // Entry beat: left modes reversed, illegal modes pass through
    always_comb begin
        entry       = '0;
        entry.valid = 1'b1;
        entry.mode  = entry_mode;
        entry.data  = is_left(entry_mode) ? rev(in_data) : in_data;
        entry.shamt = is_legal(in_mode) ? in_shamt : '0;
        entry.fill  = (entry_mode == SH_SRA) && in_data[WIDTH-1];
    end

    // Slot j may load when it or any later slot is free
    always_comb begin
        logic acc;
        rdy = '0;
        acc = out_ready;
        for (int j = LATENCY - 1; j >= 0; j--) begin
            acc    = acc || !slot_q[j].valid;
            rdy[j] = acc;
        end
    end

    assign in_ready = rdy[0];

    // Slot registers advance together, holding under backpressure
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int j = 0; j < LATENCY; j++) begin
                slot_q[j] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                if (in_valid) begin
                    slot_q[0] <= entry;
                end else begin
                    slot_q[0].valid <= 1'b0;
                end
            end
            for (int j = 1; j < LATENCY; j++) begin
                if (rdy[j]) begin
                    if (slot_q[j-1].valid) begin
                        slot_q[j]      <= slot_q[j-1];
                        slot_q[j].data <= grp[j-1];
                    end else begin
                        slot_q[j].valid <= 1'b0;
                    end
                end
            end
        end
    end

    for (genvar j = 0; j < LATENCY; j++) begin : g_slot
        localparam int LAST = ((j + 1) * REG_EVERY < SHAMT_W)
                            ? (j + 1) * REG_EVERY - 1
                            : SHAMT_W - 1;
        assign rot[j] = is_rotate(slot_q[j].mode);
        assign grp[j] = st_out[LAST];
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int J = k / REG_EVERY;
        logic [WIDTH-1:0] din;
        if (k % REG_EVERY == 0) begin : g_head
            assign din = slot_q[J].data;
        end else begin : g_body
            assign din = st_out[k-1];
        end
        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .data   (din),
            .en     (slot_q[J].shamt[k]),
            .fill   (slot_q[J].fill),
            .rotate (rot[J]),
            .result (st_out[k])
        );
    end

    assign out_valid = slot_q[LATENCY-1].valid;
    assign out_data  = is_left(slot_q[LATENCY-1].mode)
                     ? rev(grp[LATENCY-1])
                     : grp[LATENCY-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for the pipelined barrel shifter, two build variants.
// Random stream checked against an arithmetic reference model.
module tb_pipelined_barrel_shifter;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [2:0]  in_mode;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        b_in_valid, b_in_ready;
    logic        b_out_valid, b_out_ready;
    logic [31:0] b_out_data;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.WIDTH(32), .REG_EVERY(1)) u_dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    pipelined_barrel_shifter #(.WIDTH(32), .REG_EVERY(5)) u_dut_r5 (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(logic [31:0] d, logic [4:0] s,
                                          logic [2:0] m);
        logic [63:0] dd;
        dd = {d, d};
        case (m)
            3'd0: return d << s;
            3'd1: return d >> s;
            3'd2: return 32'($signed(d) >>> s);
            3'd3: begin dd = dd >> s; return dd[31:0]; end
            3'd4: begin dd = dd << s; return dd[63:32]; end
            default: return d;
        endcase
    endfunction

    task automatic run_one(input bit sel, input logic [2:0] mode,
                           input logic [31:0] d, input logic [4:0] s,
                           input logic [31:0] exp, input int lat,
                           input string tag);
        int cyc;
        bit seen;
        @(negedge clk);
        in_data     = d;
        in_shamt    = s;
        in_mode     = mode;
        out_ready   = 1'b1;
        b_out_ready = 1'b1;
        if (sel) b_in_valid = 1'b1;
        else     in_valid   = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        b_in_valid = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        while (cyc <= 20) begin
            if (sel ? b_out_valid : out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(lat));
        check(tag, sel ? b_out_data : out_data, exp);
    endtask

    initial begin
        int sent;
        int cyc;
        logic [2:0] modes [5];
        n_rst       = 1'b0;
        in_valid    = 1'b0;
        b_in_valid  = 1'b0;
        out_ready   = 1'b1;
        b_out_ready = 1'b1;
        in_data     = '0;
        in_shamt    = '0;
        in_mode     = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        n_rst = 1'b1;

        run_one(0, 3'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 5, "sra31");
        run_one(0, 3'd1, 32'h8000_0000, 5'd31, 32'h0000_0001, 5, "srl31");
        run_one(0, 3'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 5, "sll31");
        run_one(0, 3'd3, 32'h1234_5678, 5'd8, 32'h7812_3456, 5, "ror8");
        run_one(0, 3'd4, 32'h1234_5678, 5'd4, 32'h2345_6781, 5, "rol4");
        run_one(0, 3'd4, 32'h1234_5678, 5'd31, 32'h091A_2B3C, 5, "rol31");
        for (int m = 0; m < 5; m++) begin
            run_one(0, 3'(m), 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 5,
                    $sformatf("shamt0_m%0d", m));
        end
        run_one(0, 3'd7, 32'hDEAD_BEEF, 5'd5, 32'hDEAD_BEEF, 5, "mode7");

        // random stream with toggling backpressure
        sent = 0;
        cyc  = 0;
        while ((sent < 20 || exp_q.size() > 0) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 20) begin
                in_valid = 1'b1;
                in_data  = $urandom;
                in_shamt = 5'($urandom_range(0, 31));
                in_mode  = 3'($urandom_range(0, 7));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("in_ready", 32'(in_ready),
                  32'((exp_q.size() < 5) || out_ready));
            if (exp_q.size() == 0) begin
                check("idle_out_valid", 32'(out_valid), 32'd0);
            end else if (out_valid && out_ready) begin
                check("stream", out_data, exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data, in_shamt, in_mode));
                sent++;
            end
        end
        in_valid = 1'b0;
        check("stream_drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // reset with beats in flight
        @(negedge clk);
        out_ready = 1'b0;
        modes[0] = 3'd1; modes[1] = 3'd3; modes[2] = 3'd2;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_shamt = 5'($urandom_range(1, 31));
            in_mode  = modes[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        n_rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        n_rst     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(out_valid), 32'd0);
        end
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // single-slot build
        run_one(1, 3'd3, 32'h0000_000F, 5'd1, 32'h8000_0007, 1, "r5_ror1");
        run_one(1, 3'd4, 32'h8000_0001, 5'd3, 32'h0000_000C, 1, "r5_rol3");
        @(negedge clk);
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        in_data     = 32'h8000_0000;
        in_shamt    = 5'd4;
        in_mode     = 3'd2;
        @(negedge clk);
        b_in_valid = 1'b0;
        in_data    = 32'h1111_1111;
        for (int i = 0; i < 4; i++) begin
            check("r5_stall_valid", 32'(b_out_valid), 32'd1);
            check("r5_stall_data", b_out_data, 32'hF800_0000);
            check("r5_stall_in_ready", 32'(b_in_ready), 32'd0);
            @(negedge clk);
        end
        b_out_ready = 1'b1;
        @(negedge clk);
        check("r5_drained", 32'(b_out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule
